csa_resolver: RTL and testbench

- Consumes one carry-save operand pair (sum vector plus carry vector, carry weighted x2) as produced by the 3:2 compression tree.
- Resolves the pair into a plain binary result with a multi-cycle chunked carry-propagate adder, CHUNK bits per cycle.
- Sits between the compressor tree and downstream binary consumers. Trades latency for a short carry chain.
- Valid/ready handshake on both the input side and the output side.

---
 rtl/csa_resolver.sv | 108 ++++++++++
 tb/tb_csa_resolver.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/csa_resolver.sv
`timescale 1ns/1ps
// Resolves a carry-save pair (sum + 2*carry) into binary, CHUNK bits per cycle; result N cycles after accept.
// No overlap: in_rdy only in IDLE, result held in DONE until out_rdy.
module csa_resolver #(
  parameter int P_SIZE = 16,
  parameter int CHUNK  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [P_SIZE-1:0] sum_i,
  input  logic [P_SIZE-1:0] carry_i,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [P_SIZE-1:0] out_sum,
  output logic              out_ovf
);

  localparam int N  = P_SIZE / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [P_SIZE-1:0] s_q, k_q, r_q, r_d;
  logic              kmsb_q, c_q;
  logic [CW-1:0]     cnt_q;
  logic              last, accept;
  logic [CHUNK-1:0]  a_chunk, b_chunk;
  logic [CHUNK:0]    chunk_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    in_rdy  = 1'b0;
    out_vld = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // rst gates in_rdy so nothing looks acceptable while reset is held
        in_rdy = ~rst;
        accept = in_vld & ~rst;
        if (accept) state_d = RUN;
      end
      RUN: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        out_vld = 1'b1;
        if (out_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // One chunk of the carry-propagate add, selected by the chunk counter
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    r_d     = r_q;
    last    = (int'(cnt_q) == N - 1);
    for (int i = 0; i < N; i++) begin
      if (int'(cnt_q) == i) begin
        a_chunk = s_q[i*CHUNK +: CHUNK];
        b_chunk = k_q[i*CHUNK +: CHUNK];
      end
    end
    chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, c_q};
    for (int i = 0; i < N; i++) begin
      if (int'(cnt_q) == i) r_d[i*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q     <= '0;
      k_q     <= '0;
      r_q     <= '0;
      kmsb_q  <= 1'b0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      out_sum <= '0;
      out_ovf <= 1'b0;
    end else if (accept) begin
      s_q    <= sum_i;
      k_q    <= {carry_i[P_SIZE-2:0], 1'b0};
      kmsb_q <= carry_i[P_SIZE-1];
      r_q    <= '0;
      c_q    <= 1'b0;
      cnt_q  <= '0;
    end else if (state_q == RUN) begin
      r_q   <= r_d;
      c_q   <= chunk_sum[CHUNK];
      cnt_q <= cnt_q + 1'b1;
      // Carry shifted out of the top of K is a weight-2^P_SIZE bit in its own right
      if (last) begin
        out_sum <= r_d;
        out_ovf <= chunk_sum[CHUNK] | kmsb_q;
      end
    end
  end

endmodule

// File: tb/tb_csa_resolver.sv
`timescale 1ns/1ps
// Bench for csa_resolver: directed corner cases, backpressure, resets, then randomized traffic vs an arithmetic model.
module tb_csa_resolver;

  logic        clk = 1'b0;
  logic        rst, in_vld, in_rdy, out_vld, out_rdy, out_ovf;
  logic [15:0] sum_i, carry_i, out_sum;
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  csa_resolver #(.P_SIZE(16), .CHUNK(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (in_vld),
    .in_rdy  (in_rdy),
    .sum_i   (sum_i),
    .carry_i (carry_i),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .out_sum (out_sum),
    .out_ovf (out_ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Reference: plain integer sum, returns {ovf, sum}
  function automatic logic [16:0] ref_v(input logic [15:0] s, input logic [15:0] c);
    logic [31:0] v;
    v = 32'(s) + 32'(c) * 32'd2;
    return {(v >= 32'h10000), v[15:0]};
  endfunction

  task automatic wait_rdy(input string tag);
    int n;
    n = 0;
    while (!in_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(in_rdy), 32'd1);
  endtask

  task automatic do_op(input logic [15:0] s, input logic [15:0] c, input int hold, input string tag);
    logic [16:0] e;
    int          edges;
    e = ref_v(s, c);
    wait_rdy({tag, "_rdy"});
    sum_i = s; carry_i = c; in_vld = 1'b1; out_rdy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_vld = 1'b0; sum_i = 16'($urandom); carry_i = 16'($urandom);
    check({tag, "_run_in_rdy"}, 32'(in_rdy), 32'd0);
    edges = 0;
    while (!out_vld && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check({tag, "_latency"}, 32'(edges), 32'd4);
    check({tag, "_sum"}, 32'(out_sum), 32'(e[15:0]));
    check({tag, "_ovf"}, 32'(out_ovf), 32'(e[16]));
    check({tag, "_done_in_rdy"}, 32'(in_rdy), 32'd0);
    repeat (hold) begin
      in_vld = 1'b1; sum_i = 16'($urandom); carry_i = 16'($urandom);
      @(negedge clk);
      check({tag, "_hold_vld"}, 32'(out_vld), 32'd1);
      check({tag, "_hold_sum"}, 32'(out_sum), 32'(e[15:0]));
      check({tag, "_hold_ovf"}, 32'(out_ovf), 32'(e[16]));
      check({tag, "_hold_in_rdy"}, 32'(in_rdy), 32'd0);
    end
    out_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_rdy = 1'b0; in_vld = 1'b0;
    check({tag, "_post_vld"}, 32'(out_vld), 32'd0);
    check({tag, "_post_in_rdy"}, 32'(in_rdy), 32'd1);
    check({tag, "_post_sum_kept"}, 32'(out_sum), 32'(e[15:0]));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          acc, res, cyc, n;
    logic [16:0] q[$];
    logic [16:0] e;

    rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b0; sum_i = '0; carry_i = '0;
    repeat (2) @(negedge clk);
    check("rst_in_rdy", 32'(in_rdy), 32'd0);
    check("rst_out_vld", 32'(out_vld), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_ovf", 32'(out_ovf), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_in_rdy", 32'(in_rdy), 32'd1);

    do_op(16'd60,   16'd3,    0, "basic");
    do_op(16'h7FFF, 16'h0001, 0, "ripple");
    do_op(16'hFFFF, 16'h0001, 0, "ovf_a");
    do_op(16'h0000, 16'h8000, 0, "ovf_kmsb");
    do_op(16'hFFFF, 16'hFFFF, 0, "ovf_max");
    do_op(16'h1234, 16'h0F0F, 10, "bp");
    do_op(16'h00AA, 16'h0055, 0, "after_bp");

    // Reset while in RUN
    wait_rdy("rstrun_rdy");
    sum_i = 16'd60; carry_i = 16'd3; in_vld = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_vld = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstrun_out_vld", 32'(out_vld), 32'd0);
    check("rstrun_in_rdy", 32'(in_rdy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rstrun_rel_in_rdy", 32'(in_rdy), 32'd1);
    check("rstrun_rel_vld", 32'(out_vld), 32'd0);
    do_op(16'd1, 16'd1, 0, "post_rst");

    // Reset while in DONE: out_vld drops without waiting for a clock
    wait_rdy("rstdone_rdy");
    sum_i = 16'd5; carry_i = 16'd5; in_vld = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_vld = 1'b0;
    n = 0;
    while (!out_vld && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rstdone_reached", 32'(out_vld), 32'd1);
    rst = 1'b1;
    #1;
    check("rstdone_out_vld", 32'(out_vld), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rstdone_rel_in_rdy", 32'(in_rdy), 32'd1);

    // Randomized traffic
    acc = 0; res = 0; cyc = 0;
    while ((acc < 1000 || res < acc) && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      check("rnd_excl", 32'(in_rdy & out_vld), 32'd0);
      in_vld  = (acc < 1000) && ($urandom_range(0, 99) < 60);
      sum_i   = 16'($urandom);
      carry_i = 16'($urandom);
      case ($urandom_range(0, 7))
        0: sum_i = 16'hFFFF;
        1: carry_i = 16'hFFFF;
        2: carry_i = 16'h8000;
        default: ;
      endcase
      out_rdy = ($urandom_range(0, 99) < 50);
      if (in_vld && in_rdy) begin
        q.push_back(ref_v(sum_i, carry_i));
        acc++;
      end
      if (out_vld && out_rdy) begin
        if (q.size() == 0) begin
          check("rnd_spurious", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("rnd_sum", 32'(out_sum), 32'(e[15:0]));
          check("rnd_ovf", 32'(out_ovf), 32'(e[16]));
        end
        res++;
      end
    end
    in_vld = 1'b0; out_rdy = 1'b0;
    check("rnd_accepts", 32'(acc), 32'd1000);
    check("rnd_results", 32'(res), 32'(acc));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
